// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Fills the instruction RAM from a byte stream (boot UART or test host)
//   before the core leaves reset. The first byte after start is the word
//   count N (0 means 2**ADDR_W words). The following bytes are packed
//   little-endian into 32-bit words. Each complete word produces a one-cycle
//   write strobe, at consecutive addresses starting from BASE_ADDR.
//
// Build option
//   INSTR_LOADER_CHECKSUM_EN : when defined, one checksum byte follows the
//     data. error is raised if it differs from the XOR of all data bytes.
//     When undefined, error is tied low and no checksum byte is expected.
//
// Parameters
//   ADDR_W     write address width (<= 8)
//   BASE_ADDR  first word address written
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           1-cycle pulse that begins a load (ignored while busy)
//   byte_in         stream byte, accepted when byte_valid && byte_ready
//   byte_valid      byte_in is valid this cycle
//   byte_ready      loader accepts byte_in this cycle
//   writeEnable     1-cycle write strobe to the instruction memory
//   writeAddress    word address for writeEnable
//   writeData       word for writeEnable
//   busy            load in progress
//   done            1-cycle pulse at the end of a load
//   error           checksum mismatch, held until the next accepted start
module instr_mem_loader #(
    parameter int unsigned           ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              writeEnable,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [31:0]       writeData,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned WORDS_MAX = 1 << ADDR_W;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] CSUM  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]       state;
    logic [1:0]       byte_cnt;
    // One bit wider than the address so that a full 2**ADDR_W load fits.
    logic [CNT_W-1:0] remaining;
    logic             accept;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
    logic             error_q;
`endif

    // Handshake and status outputs are pure decodes of the state, so the
    // reset state already produces their reset values.
    assign byte_ready  = (state == LEN) || (state == DATA)
`ifdef INSTR_LOADER_CHECKSUM_EN
                      || (state == CSUM)
`endif
                      ;
    assign accept      = byte_valid && byte_ready;
    assign writeEnable = (state == WRITE);
    assign busy        = (state == LEN) || (state == DATA) ||
                         (state == WRITE) || (state == CSUM);
    assign done        = (state == DONE);

`ifdef INSTR_LOADER_CHECKSUM_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            remaining    <= '0;
            writeAddress <= BASE_ADDR;
            writeData    <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum         <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= LEN;
                        byte_cnt     <= '0;
                        writeAddress <= BASE_ADDR;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum         <= '0;
                        error_q      <= 1'b0;
`endif
                    end
                end

                LEN: begin
                    if (accept) begin
                        // A count of zero encodes the full address range.
                        if (byte_in[ADDR_W-1:0] == '0)
                            remaining <= CNT_W'(WORDS_MAX);
                        else
                            remaining <= {1'b0, byte_in[ADDR_W-1:0]};
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (accept) begin
                        writeData[{byte_cnt, 3'b000} +: 8] <= byte_in;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_in;
`endif
                        if (byte_cnt == 2'd3)
                            state <= WRITE;
                    end
                end

                WRITE: begin
                    // writeData/writeAddress held through the strobe cycle;
                    // the address advances only once the strobe is over.
                    writeAddress <= writeAddress + 1'b1;
                    remaining    <= remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state <= CSUM;
`else
                        state <= DONE;
`endif
                    end else begin
                        state <= DATA;
                    end
                end

`ifdef INSTR_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        error_q <= (byte_in != csum);
                        state   <= DONE;
                    end
                end
`endif

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        a_ready, a_we, a_busy, a_done, a_error;
    logic [7:0]  a_addr;
    logic [31:0] a_data;
    logic        b_ready, b_we, b_busy, b_done, b_error;
    logic [7:0]  b_addr;
    logic [31:0] b_data;

    int compared   = 0;
    int mismatched = 0;

    // write / done log filled by the monitor
    int          cyc = 0;
    int          wr_n, done_n, we_cyc, done_cyc, ready_viol, stalls, wr_at_done;
    logic        busy_at_done, err_at_done;
    logic [7:0]  wr_addr  [0:511];
    logic [31:0] wr_data  [0:511];
    logic [7:0]  wrb_addr [0:511];

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut_a (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(a_ready), .writeEnable(a_we),
        .writeAddress(a_addr), .writeData(a_data), .busy(a_busy),
        .done(a_done), .error(a_error)
    );

    instr_mem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut_b (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(b_ready), .writeEnable(b_we),
        .writeAddress(b_addr), .writeData(b_data), .busy(b_busy),
        .done(b_done), .error(b_error)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (a_we) begin
            if (wr_n < 512) begin
                wr_addr[wr_n]  = a_addr;
                wr_data[wr_n]  = a_data;
                wrb_addr[wr_n] = b_addr;
            end
            wr_n++;
            we_cyc = cyc;
            if (a_ready) ready_viol++;
        end
        if (a_done) begin
            done_n++;
            done_cyc     = cyc;
            busy_at_done = a_busy;
            err_at_done  = a_error;
            wr_at_done   = wr_n;
        end
    end

    task automatic clear_logs();
        wr_n = 0; done_n = 0; we_cyc = 0; done_cyc = 0;
        ready_viol = 0; stalls = 0; wr_at_done = 0;
        busy_at_done = 1'b0; err_at_done = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (a_ready) got = 1'b1;
            @(posedge clk); #1;
        end
        if (!got) stalls++;
        byte_valid = 1'b0;
    endtask

    task automatic send_csum(input logic [7:0] c);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(c);
`else
        byte_in = c;
`endif
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            if (done_n > 0) ok = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++; if (a_ready !== 1'b0) begin mismatched++; $display("FAIL rst_ready: got %b expected 0", a_ready); end
        compared++; if (a_we !== 1'b0) begin mismatched++; $display("FAIL rst_we: got %b expected 0", a_we); end
        compared++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin mismatched++; $display("FAIL rst_busy_done: got %b%b expected 00", a_busy, a_done); end
        compared++; if (a_error !== 1'b0) begin mismatched++; $display("FAIL rst_error: got %b expected 0", a_error); end
        compared++; if (a_addr !== 8'h00) begin mismatched++; $display("FAIL rst_addr_a: got %h expected 00", a_addr); end
        compared++; if (b_addr !== 8'hFE) begin mismatched++; $display("FAIL rst_addr_b: got %h expected fe", b_addr); end
        compared++; if (a_data !== 32'h0) begin mismatched++; $display("FAIL rst_data: got %h expected 00000000", a_data); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        bit ok;
        clear_logs();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_csum(8'h08);
        wait_done(ok);
        compared++; if (ok !== 1'b1 || stalls != 0) begin mismatched++; $display("FAIL t1_done_seen: got ok=%0d stalls=%0d expected 1/0", ok, stalls); end
        compared++; if (wr_n != 1) begin mismatched++; $display("FAIL t1_writes: got %0d expected 1", wr_n); end
        compared++; if (wr_addr[0] !== 8'h00) begin mismatched++; $display("FAIL t1_addr: got %h expected 00", wr_addr[0]); end
        compared++; if (wr_data[0] !== 32'h12345678) begin mismatched++; $display("FAIL t1_data: got %h expected 12345678", wr_data[0]); end
`ifndef INSTR_LOADER_CHECKSUM_EN
        compared++; if (done_cyc != we_cyc + 1) begin mismatched++; $display("FAIL t1_done_lat: got %0d expected %0d", done_cyc, we_cyc + 1); end
`endif
        compared++; if (busy_at_done !== 1'b0) begin mismatched++; $display("FAIL t1_busy_at_done: got %b expected 0", busy_at_done); end
        compared++; if (err_at_done !== 1'b0) begin mismatched++; $display("FAIL t1_error: got %b expected 0", err_at_done); end
        repeat (3) @(posedge clk);
        #1;
        compared++; if (done_n != 1) begin mismatched++; $display("FAIL t1_done_count: got %0d expected 1", done_n); end
        compared++; if (a_addr !== 8'h01) begin mismatched++; $display("FAIL t1_addr_after: got %h expected 01", a_addr); end
    endtask

    task automatic test_gaps();
        bit ok;
        clear_logs();
        pulse_start();
        send_byte(8'h03);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;           // one idle cycle between bytes
            send_byte(8'(i));
        end
        send_csum(8'h00);
        wait_done(ok);
        compared++; if (ok !== 1'b1 || stalls != 0) begin mismatched++; $display("FAIL t2_done_seen: got ok=%0d stalls=%0d expected 1/0", ok, stalls); end
        compared++; if (wr_n != 3) begin mismatched++; $display("FAIL t2_writes: got %0d expected 3", wr_n); end
        compared++; if (wr_addr[0] !== 8'h00 || wr_addr[1] !== 8'h01 || wr_addr[2] !== 8'h02) begin mismatched++; $display("FAIL t2_addrs: got %h %h %h expected 00 01 02", wr_addr[0], wr_addr[1], wr_addr[2]); end
        compared++; if (wr_data[0] !== 32'h03020100) begin mismatched++; $display("FAIL t2_data0: got %h expected 03020100", wr_data[0]); end
        compared++; if (wr_data[1] !== 32'h07060504) begin mismatched++; $display("FAIL t2_data1: got %h expected 07060504", wr_data[1]); end
        compared++; if (wr_data[2] !== 32'h0B0A0908) begin mismatched++; $display("FAIL t2_data2: got %h expected 0b0a0908", wr_data[2]); end
        compared++; if (ready_viol != 0) begin mismatched++; $display("FAIL t2_ready_in_write: got %0d expected 0", ready_viol); end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_logs();
        pulse_start();
        send_byte(8'h03);
        for (int i = 0; i < 12; i++) send_byte(8'(i));
        send_csum(8'h00);
        wait_done(ok);
        compared++; if (ok !== 1'b1 || wr_n != 3) begin mismatched++; $display("FAIL t3_writes: got ok=%0d n=%0d expected 1/3", ok, wr_n); end
        compared++; if (wrb_addr[0] !== 8'hFE || wrb_addr[1] !== 8'hFF || wrb_addr[2] !== 8'h00) begin mismatched++; $display("FAIL t3_wrap_addrs: got %h %h %h expected fe ff 00", wrb_addr[0], wrb_addr[1], wrb_addr[2]); end
        compared++; if (b_addr !== 8'h01) begin mismatched++; $display("FAIL t3_addr_after: got %h expected 01", b_addr); end
    endtask

    task automatic test_full_range();
        bit ok;
        int bad = 0;
        logic [7:0] v;
        clear_logs();
        pulse_start();
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            send_byte(8'hA5); send_byte(v); send_byte(~v); send_byte(v);
        end
        send_csum(8'h00);
        wait_done(ok);
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            if (wr_addr[i] !== v || wr_data[i] !== {v, ~v, v, 8'hA5}) bad++;
        end
        compared++; if (ok !== 1'b1 || stalls != 0) begin mismatched++; $display("FAIL t4_done_seen: got ok=%0d stalls=%0d expected 1/0", ok, stalls); end
        compared++; if (wr_n != 256) begin mismatched++; $display("FAIL t4_writes: got %0d expected 256", wr_n); end
        compared++; if (wr_at_done != 256) begin mismatched++; $display("FAIL t4_writes_at_done: got %0d expected 256", wr_at_done); end
        compared++; if (bad != 0) begin mismatched++; $display("FAIL t4_seq: got %0d bad words expected 0", bad); end
        compared++; if (done_n != 1) begin mismatched++; $display("FAIL t4_done_count: got %0d expected 1", done_n); end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        clear_logs();
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        @(posedge clk); #1;               // past the second WRITE cycle
        compared++; if (wr_n != 2) begin mismatched++; $display("FAIL t5_writes_before: got %0d expected 2", wr_n); end
        reset = 1'b1;
        @(negedge clk);                   // still before the reset edge
        @(negedge clk);
        compared++; if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_we !== 1'b0) begin mismatched++; $display("FAIL t5_ctrl_reset: got busy=%b ready=%b we=%b expected 000", a_busy, a_ready, a_we); end
        compared++; if (a_addr !== 8'h00 || b_addr !== 8'hFE) begin mismatched++; $display("FAIL t5_addr_reset: got %h/%h expected 00/fe", a_addr, b_addr); end
        compared++; if (a_data !== 32'h0) begin mismatched++; $display("FAIL t5_data_reset: got %h expected 00000000", a_data); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        compared++; if (done_n != 0) begin mismatched++; $display("FAIL t5_no_done: got %0d expected 0", done_n); end
        clear_logs();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_csum(8'h22);
        wait_done(ok);
        compared++; if (ok !== 1'b1 || wr_n != 1) begin mismatched++; $display("FAIL t5_reload_writes: got ok=%0d n=%0d expected 1/1", ok, wr_n); end
        compared++; if (wr_addr[0] !== 8'h00 || wrb_addr[0] !== 8'hFE) begin mismatched++; $display("FAIL t5_reload_addr: got %h/%h expected 00/fe", wr_addr[0], wrb_addr[0]); end
        compared++; if (wr_data[0] !== 32'hEFBEADDE) begin mismatched++; $display("FAIL t5_reload_data: got %h expected efbeadde", wr_data[0]); end
    endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bit ok;
        clear_logs();
        pulse_start();
        send_byte(8'h01);
        // XOR of AA,BB,CC,DE is 03, so a checksum byte of 00 is wrong
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDE);
        send_byte(8'h00);
        wait_done(ok);
        compared++; if (ok !== 1'b1 || err_at_done !== 1'b1) begin mismatched++; $display("FAIL t6_error_set: got ok=%0d err=%b expected 1/1", ok, err_at_done); end
        repeat (3) @(posedge clk);
        #1;
        compared++; if (a_error !== 1'b1) begin mismatched++; $display("FAIL t6_error_held: got %b expected 1", a_error); end
        clear_logs();
        pulse_start();
        @(negedge clk);
        compared++; if (a_error !== 1'b0) begin mismatched++; $display("FAIL t6_error_cleared: got %b expected 0", a_error); end
        @(posedge clk); #1;
        send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h11); send_byte(8'h22); send_byte(8'h22);
        send_byte(8'h00);
        wait_done(ok);
        compared++; if (ok !== 1'b1 || err_at_done !== 1'b0) begin mismatched++; $display("FAIL t6_error_clean: got ok=%0d err=%b expected 1/0", ok, err_at_done); end
    endtask
`endif

    initial begin
        clear_logs();
        test_reset();
        test_single_word();
        test_gaps();
        test_wrap();
        test_full_range();
        test_reset_mid_load();
`ifdef INSTR_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
